seg_scan_driver: RTL

//  Time-multiplexed scan driver for an N-digit 7-segment display.

---
 rtl/seg_scan_pkg.sv | 22 ++
 rtl/seg_scan_timer.sv | 26 ++
 rtl/seg_scan_driver.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 7-segment scan driver.
package seg_scan_pkg;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned MAX_DIGITS = 16;

    typedef enum logic [1:0] {BLANK, SHOW, GUARD} scan_state_t;

    // word is zero-extended by the caller to MAX_DIGITS digits
    function automatic logic [NIBBLE_W-1:0] digit_of(
        input logic [NIBBLE_W*MAX_DIGITS-1:0] word,
        input int unsigned                    idx
    );
        logic [NIBBLE_W-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i == idx) d = word[i*NIBBLE_W +: NIBBLE_W];
        end
        return d;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter timing one scan slot; expire is high on the slot's last cycle.
module seg_scan_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/seg_scan_driver.sv
// Double-buffered time-multiplexed scan driver for an N-digit 7-segment display.
// Optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4*NUM_DIGITS-1:0]    in_data,
    output logic [3:0]                 out_nibble,
    output logic [NUM_DIGITS-1:0]      out_digit_sel,
    output logic                       out_blank,
    output logic                       frame_done
);

    localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);
    localparam int unsigned WORD_W    = NIBBLE_W * NUM_DIGITS;
    localparam int unsigned SLOT_MAX  = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int unsigned TMR_W     = $clog2(SLOT_MAX + 1);
    localparam int unsigned GUARD_LEN = (GUARD_CYCLES > 0) ? GUARD_CYCLES : 1;

    localparam logic [TMR_W-1:0] SHOW_LOAD  = TMR_W'(REFRESH_DIV - 1);
    localparam logic [TMR_W-1:0] GUARD_LOAD = TMR_W'(GUARD_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t               state, state_n;
    logic [IDX_W-1:0]          idx, idx_n;
    logic [WORD_W-1:0]         active, active_n, shadow;
    logic                      pending, pending_n;
    logic                      accept, advance, wrap;
    logic                      tmr_load, expire;
    logic [TMR_W-1:0]          tmr_val;
    logic                      suppress;
    logic [NIBBLE_W*MAX_DIGITS-1:0] active_ext;
    logic [3:0]                nib_n;
    logic [NUM_DIGITS-1:0]     sel_n;
    logic                      blank_n;

    assign in_ready   = ~pending;
    assign accept     = in_valid & ~pending;
    assign active_ext = (NIBBLE_W*MAX_DIGITS)'(active_n);

    seg_scan_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BLANK;
            idx     <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            active  <= active_n;
            pending <= pending_n;
            if (accept) shadow <= in_data;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        tmr_load = 1'b0;
        tmr_val  = SHOW_LOAD;
        advance  = 1'b0;
        case (state)
            BLANK: if (accept) begin
                state_n  = SHOW;
                idx_n    = '0;
                tmr_load = 1'b1;
            end
            SHOW: if (expire) begin
                tmr_load = 1'b1;
                if (GUARD_CYCLES > 0) begin
                    state_n = GUARD;
                    tmr_val = GUARD_LOAD;
                end else begin
                    advance = 1'b1;
                end
            end
            GUARD: if (expire) begin
                state_n  = SHOW;
                tmr_load = 1'b1;
                advance  = 1'b1;
            end
            default: state_n = BLANK;
        endcase
        if (advance) idx_n = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end

    assign wrap = advance && (idx == LAST_IDX);

    // An accept on the wrap cycle only fills shadow; it is shown from the following wrap.
    always_comb begin
        active_n  = active;
        pending_n = pending;
        if (state == BLANK) begin
            if (accept) active_n = in_data;
        end else begin
            if (wrap && pending) begin
                active_n  = shadow;
                pending_n = 1'b0;
            end
            if (accept) pending_n = 1'b1;
        end
    end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            zero_run = zero_run && (digit_of(active_ext, NUM_DIGITS - 1 - j) == '0);
            lead_zero[NUM_DIGITS - 1 - j] = zero_run;
        end
    end
    assign suppress = (idx_n != '0) && lead_zero[idx_n];
`else
    assign suppress = 1'b0;
`endif

    // Outputs are computed from next-cycle state so they line up with the state register.
    always_comb begin
        nib_n   = out_nibble;
        sel_n   = '0;
        blank_n = 1'b1;
        if (state_n == SHOW) begin
            nib_n = digit_of(active_ext, 32'(idx_n));
            if (!suppress) begin
                sel_n   = NUM_DIGITS'(1) << idx_n;
                blank_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_nibble    <= '0;
            out_digit_sel <= '0;
            out_blank     <= 1'b1;
            frame_done    <= 1'b0;
        end else begin
            out_nibble    <= nib_n;
            out_digit_sel <= sel_n;
            out_blank     <= blank_n;
            frame_done    <= wrap;
        end
    end

endmodule
